tcdm_bank_init_arb: RTL



---
 rtl/tcdm_init_pkg.sv | 33 +++
 rtl/tcdm_bank_init_arb_if.sv | 31 +++
 rtl/tcdm_fill_sweep.sv | 56 +++++
 rtl/tcdm_bank_init_arb.sv | 103 ++++++++++
 4 files changed

// File: rtl/tcdm_init_pkg.sv
// Shared types for the TCDM bank front-end: FSM states and the bank request
// bundle used by the arbitration mux.
package tcdm_init_pkg;

    // Widest bank address carried in the request struct; banks up to 64k words.
    localparam int unsigned ADDR_W_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    typedef struct packed {
        logic                  req;
        logic                  wen;
        logic [ADDR_W_MAX-1:0] add;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } bank_req_t;

    // Full-word write of the fill constant at the given address.
    function automatic bank_req_t fill_req(input logic [ADDR_W_MAX-1:0] add,
                                           input logic [31:0]           value);
        bank_req_t r;
        r.req   = 1'b1;
        r.wen   = 1'b0;
        r.add   = add;
        r.wdata = value;
        r.be    = 4'hF;
        return r;
    endfunction

endpackage

// File: rtl/tcdm_bank_init_arb_if.sv
// Bank-port bundle: interconnect master side plus the SRAM side of one bank.
interface tcdm_bank_init_arb_if #(
    parameter int unsigned AW = 8
) ();
    logic          req_i;
    logic          wen_i;
    logic [AW-1:0] add_i;
    logic [31:0]   wdata_i;
    logic [3:0]    be_i;
    logic          gnt_o;
    logic          r_valid_o;
    logic [31:0]   r_rdata_o;
    logic          bank_req_o;
    logic          bank_wen_o;
    logic [AW-1:0] bank_add_o;
    logic [31:0]   bank_wdata_o;
    logic [3:0]    bank_be_o;
    logic [31:0]   bank_rdata_i;

    modport slave (
        input  req_i, wen_i, add_i, wdata_i, be_i, bank_rdata_i,
        output gnt_o, r_valid_o, r_rdata_o,
               bank_req_o, bank_wen_o, bank_add_o, bank_wdata_o, bank_be_o
    );

    modport master (
        output req_i, wen_i, add_i, wdata_i, be_i, bank_rdata_i,
        input  gnt_o, r_valid_o, r_rdata_o,
               bank_req_o, bank_wen_o, bank_add_o, bank_wdata_o, bank_be_o
    );
endinterface

// File: rtl/tcdm_fill_sweep.sv
// Fill address sweep and master-stall budget for the bank init engine;
// also produces the registered completion pulse.
module tcdm_fill_sweep #(
    parameter int unsigned BANK_SIZE = 256,
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned AW        = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          slot_i,
    input  logic          stall_i,
    output logic [AW-1:0] fill_cnt_o,
    output logic          stall_full_o,
    output logic          last_o,
    output logic          done_o
);
    localparam int unsigned SW = $clog2(MAX_STALL + 1);

    logic [AW-1:0] fill_cnt_q, fill_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          done_q, done_d;

    assign last_o       = (fill_cnt_q == AW'(BANK_SIZE - 1));
    assign stall_full_o = (stall_cnt_q == SW'(MAX_STALL));
    assign fill_cnt_o   = fill_cnt_q;
    assign done_o       = done_q;

    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (start_i) begin
            fill_cnt_d  = '0;
            stall_cnt_d = '0;
        end else if (slot_i) begin
            // Wraps to 0 after the last word, leaving the counter ready for a restart.
            fill_cnt_d  = fill_cnt_q + AW'(1);
            stall_cnt_d = '0;
        end else if (stall_i) begin
            stall_cnt_d = stall_cnt_q + SW'(1);
        end
        done_d = slot_i & last_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_cnt_q  <= '0;
            stall_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: rtl/tcdm_bank_init_arb.sv
// TCDM bank front-end: shares one 1-cycle SRAM bank between the interconnect
// master and a constant-fill engine with bounded master starvation.
module tcdm_bank_init_arb
    import tcdm_init_pkg::*;
#(
    parameter int unsigned BANK_SIZE  = 256,
    parameter logic [31:0] INIT_VALUE = 32'h0,
    parameter bit          INIT_PRIO  = 1'b0,
    parameter int unsigned MAX_STALL  = 8,
    localparam int unsigned AW        = $clog2(BANK_SIZE)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_i,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    tcdm_bank_init_arb_if.slave  bus
);
    state_e        state_q, state_d;
    logic          slot, gnt, start, stall_gnt;
    logic          stall_full, last;
    logic [AW-1:0] fill_cnt;
    logic          r_valid_q, r_valid_d;
    bank_req_t     mst_req, bank_req;

    assign start     = (state_q == IDLE) & init_i;
    assign stall_gnt = (state_q == FILL) & gnt;

    tcdm_fill_sweep #(
        .BANK_SIZE (BANK_SIZE),
        .MAX_STALL (MAX_STALL),
        .AW        (AW)
    ) u_sweep (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start),
        .slot_i       (slot),
        .stall_i      (stall_gnt),
        .fill_cnt_o   (fill_cnt),
        .stall_full_o (stall_full),
        .last_o       (last),
        .done_o       (init_done_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // init_i is only looked at in IDLE, so a pulse during a fill is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (init_i) state_d = FILL;
            FILL:    if (slot && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slot = 1'b0;
        gnt  = 1'b0;
        case (state_q)
            IDLE: gnt = bus.req_i;
            // Fill takes the cycle when prioritised, idle, or the stall budget is spent.
            FILL: begin
                if (INIT_PRIO || !bus.req_i || stall_full) slot = 1'b1;
                else                                       gnt  = 1'b1;
            end
            default: ;
        endcase

        mst_req.req   = gnt;
        mst_req.wen   = bus.wen_i;
        mst_req.add   = ADDR_W_MAX'(bus.add_i);
        mst_req.wdata = bus.wdata_i;
        mst_req.be    = bus.be_i;

        bank_req  = slot ? fill_req(ADDR_W_MAX'(fill_cnt), INIT_VALUE) : mst_req;
        r_valid_d = bus.req_i & gnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= r_valid_d;
        end
    end

    assign bus.gnt_o        = gnt;
    assign bus.r_valid_o    = r_valid_q;
    assign bus.r_rdata_o    = bus.bank_rdata_i;
    assign bus.bank_req_o   = bank_req.req;
    assign bus.bank_wen_o   = bank_req.wen;
    assign bus.bank_add_o   = AW'(bank_req.add);
    assign bus.bank_wdata_o = bank_req.wdata;
    assign bus.bank_be_o    = bank_req.be;
    assign init_busy_o      = (state_q == FILL);
endmodule
